term_write_arbiter: RTL and testbench

Arbiter and sequencer for the single write port of the text-mode character buffer (ROWS×COLS cells, each holding ASCII, 3-bit foreground and 3-bit background colour). The block shares that port between two requesters (for example keyboard echo and a demo pattern generator) using valid/ready handshakes and round-robin priority. It also runs a full-screen clear sweep that takes priority over both requesters. Its outputs connect directly to the buffer's write interface.

---
 rtl/term_write_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_term_write_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/term_write_arbiter.sv
// term_write_arbiter: shares the single write port of the text-mode character
// buffer between two requesters, with round-robin priority. It also runs a
// full-screen clear sweep that takes priority over both requesters. All
// buffer-side outputs are registered.
module term_write_arbiter #(
  parameter int ROWS = 30,
  parameter int COLS = 70
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  // clear sweep control
  input  logic       clr_req_i,
  input  logic [7:0] clr_ascii_i,
  input  logic [2:0] clr_fg_i,
  input  logic [2:0] clr_bg_i,
  output logic       clr_busy_o,
  // requester 0
  input  logic       req0_valid_i,
  output logic       req0_ready_o,
  input  logic [4:0] req0_row_i,
  input  logic [6:0] req0_col_i,
  input  logic [7:0] req0_ascii_i,
  input  logic [2:0] req0_fg_i,
  input  logic [2:0] req0_bg_i,
  // requester 1
  input  logic       req1_valid_i,
  output logic       req1_ready_o,
  input  logic [4:0] req1_row_i,
  input  logic [6:0] req1_col_i,
  input  logic [7:0] req1_ascii_i,
  input  logic [2:0] req1_fg_i,
  input  logic [2:0] req1_bg_i,
  // buffer write port
  output logic       we_o,
  output logic [4:0] wr_addr_o,
  output logic [6:0] wc_addr_o,
  output logic [7:0] w_ascii_o,
  output logic [2:0] fg_color_o,
  output logic [2:0] bg_color_o,
  output logic       oob_drop_o,
  // debug: current FSM state (0 = IDLE, 1 = CLEAR)
  output logic       dbg_state_o
);

  // Handshake: a write moves from requester i when reqi_valid_i && reqi_ready_o
  // are both high in the same cycle. Ready is combinational and never
  // depends on the requester's own payload. The requester must keep valid and
  // payload stable until ready is seen. At most one ready is high per cycle.

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  localparam logic [5:0] ROWS_LIM = 6'(ROWS);
  localparam logic [7:0] COLS_LIM = 8'(COLS);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  // A 1x1 screen finishes its sweep in the same cycle the clear is accepted.
  localparam bit         ONE_CELL = (ROWS == 1) && (COLS == 1);

  state_e     state_q;
  logic       last_grant_q;
  logic [4:0] cur_row_q, cur_row_d;
  logic [6:0] cur_col_q, cur_col_d;
  logic [7:0] fill_ascii_q;
  logic [2:0] fill_fg_q, fill_bg_q;

  logic       we_q, oob_q, busy_q;
  logic [4:0] wr_addr_q;
  logic [6:0] wc_addr_q;
  logic [7:0] w_ascii_q;
  logic [2:0] fg_q, bg_q;

  logic       arb_en, grant0, grant1, at_last;
  logic [4:0] sel_row;
  logic [6:0] sel_col;
  logic [7:0] sel_ascii;
  logic [2:0] sel_fg, sel_bg;
  logic       sel_oob;

  // Arbitration: clear requests and the sweep block both requesters; on a tie
  // the requester that did not win the last transfer is granted.
  always_comb begin
    arb_en = rst_ni && (state_q == S_IDLE) && !clr_req_i;
    grant0 = arb_en && req0_valid_i && (!req1_valid_i || last_grant_q);
    grant1 = arb_en && req1_valid_i && (!req0_valid_i || !last_grant_q);
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  // Payload of the granted requester and its range check (unsigned, widened).
  always_comb begin
    sel_row   = req0_row_i;
    sel_col   = req0_col_i;
    sel_ascii = req0_ascii_i;
    sel_fg    = req0_fg_i;
    sel_bg    = req0_bg_i;
    if (grant1) begin
      sel_row   = req1_row_i;
      sel_col   = req1_col_i;
      sel_ascii = req1_ascii_i;
      sel_fg    = req1_fg_i;
      sel_bg    = req1_bg_i;
    end
    sel_oob = ({1'b0, sel_row} >= ROWS_LIM) || ({1'b0, sel_col} >= COLS_LIM);
  end

  // Sweep cursor successor: from IDLE the cell after (0,0), otherwise the
  // row-major successor of the current cursor.
  always_comb begin
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    at_last   = (cur_row_q == LAST_ROW) && (cur_col_q == LAST_COL);
    if (state_q == S_IDLE) begin
      if (LAST_COL == 7'd0) begin
        cur_row_d = 5'd1;
        cur_col_d = 7'd0;
      end else begin
        cur_row_d = 5'd0;
        cur_col_d = 7'd1;
      end
    end else if (cur_col_q == LAST_COL) begin
      cur_row_d = cur_row_q + 5'd1;
      cur_col_d = 7'd0;
    end else begin
      cur_col_d = cur_col_q + 7'd1;
    end
  end

  // Main FSM: owns state, round-robin pointer, sweep cursor, fill values and
  // every registered output of the write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      cur_row_q    <= 5'd0;
      cur_col_q    <= 7'd0;
      fill_ascii_q <= 8'd0;
      fill_fg_q    <= 3'd0;
      fill_bg_q    <= 3'd0;
      we_q         <= 1'b0;
      oob_q        <= 1'b0;
      busy_q       <= 1'b0;
      wr_addr_q    <= 5'd0;
      wc_addr_q    <= 7'd0;
      w_ascii_q    <= 8'd0;
      fg_q         <= 3'd0;
      bg_q         <= 3'd0;
    end else begin
      we_q   <= 1'b0;
      oob_q  <= 1'b0;
      busy_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (clr_req_i) begin
            fill_ascii_q <= clr_ascii_i;
            fill_fg_q    <= clr_fg_i;
            fill_bg_q    <= clr_bg_i;
            we_q         <= 1'b1;
            busy_q       <= 1'b1;
            wr_addr_q    <= 5'd0;
            wc_addr_q    <= 7'd0;
            w_ascii_q    <= clr_ascii_i;
            fg_q         <= clr_fg_i;
            bg_q         <= clr_bg_i;
            cur_row_q    <= cur_row_d;
            cur_col_q    <= cur_col_d;
            state_q      <= ONE_CELL ? S_IDLE : S_CLEAR;
          end else if (grant0 || grant1) begin
            last_grant_q <= grant1;
            if (sel_oob) begin
              oob_q <= 1'b1;
            end else begin
              we_q      <= 1'b1;
              wr_addr_q <= sel_row;
              wc_addr_q <= sel_col;
              w_ascii_q <= sel_ascii;
              fg_q      <= sel_fg;
              bg_q      <= sel_bg;
            end
          end
        end
        S_CLEAR: begin
          we_q      <= 1'b1;
          busy_q    <= 1'b1;
          wr_addr_q <= cur_row_q;
          wc_addr_q <= cur_col_q;
          w_ascii_q <= fill_ascii_q;
          fg_q      <= fill_fg_q;
          bg_q      <= fill_bg_q;
          cur_row_q <= cur_row_d;
          cur_col_q <= cur_col_d;
          if (at_last) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign we_o        = we_q;
  assign oob_drop_o  = oob_q;
  assign clr_busy_o  = busy_q;
  assign wr_addr_o   = wr_addr_q;
  assign wc_addr_o   = wc_addr_q;
  assign w_ascii_o   = w_ascii_q;
  assign fg_color_o  = fg_q;
  assign bg_color_o  = bg_q;
  assign dbg_state_o = (state_q == S_CLEAR);

endmodule

// File: tb/tb_term_write_arbiter.sv
// Testbench for term_write_arbiter: table-driven vectors, hand-written
// multi-cycle sequences and a randomized phase, all cross-checked by a
// behavioural model that predicts every cycle's ready and output values.
`timescale 1ns/1ps
module tb_term_write_arbiter;

  localparam int ROWS  = 30;
  localparam int COLS  = 70;
  localparam int NCELL = ROWS * COLS;
  localparam int W     = 29;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_req;
  logic [7:0] clr_ascii;
  logic [2:0] clr_fg, clr_bg;
  logic       v0, v1;
  logic [4:0] row0, row1;
  logic [6:0] col0, col1;
  logic [7:0] asc0, asc1;
  logic [2:0] fg0, bg0, fg1, bg1;

  logic       clr_busy, rdy0, rdy1, we, oob, dbg_state;
  logic [4:0] wr_addr;
  logic [6:0] wc_addr;
  logic [7:0] w_ascii;
  logic [2:0] fg_color, bg_color;

  always #5 clk = ~clk;

  term_write_arbiter #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .clr_req_i(clr_req), .clr_ascii_i(clr_ascii), .clr_fg_i(clr_fg), .clr_bg_i(clr_bg),
    .clr_busy_o(clr_busy),
    .req0_valid_i(v0), .req0_ready_o(rdy0), .req0_row_i(row0), .req0_col_i(col0),
    .req0_ascii_i(asc0), .req0_fg_i(fg0), .req0_bg_i(bg0),
    .req1_valid_i(v1), .req1_ready_o(rdy1), .req1_row_i(row1), .req1_col_i(col1),
    .req1_ascii_i(asc1), .req1_fg_i(fg1), .req1_bg_i(bg1),
    .we_o(we), .wr_addr_o(wr_addr), .wc_addr_o(wc_addr), .w_ascii_o(w_ascii),
    .fg_color_o(fg_color), .bg_color_o(bg_color), .oob_drop_o(oob),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Clear sweep = "cells remaining" counter plus linear cell index; the cell
  // address is recovered with divide/modulo. Outputs are predicted one cycle
  // ahead and queued.
  int         m_lg;
  int         m_left;
  int         m_idx;
  logic [7:0] m_fa;
  logic [2:0] m_ff, m_fb;
  logic [4:0] h_row;
  logic [6:0] h_col;
  logic [7:0] h_asc;
  logic [2:0] h_fg, h_bg;
  logic [W-1:0] exp_q[$];

  always @(negedge clk) begin : model
    logic [W-1:0] act, e;
    logic         e_r0, e_r1, n_we, n_oob, n_busy;
    int           g;
    act = {we, oob, clr_busy, wr_addr, wc_addr, w_ascii, fg_color, bg_color};
    if (rst_n !== 1'b1) begin
      check("reset_outputs", 32'(act), 32'd0);
      check("reset_ready", {30'd0, rdy0, rdy1}, 32'd0);
      m_lg = 1; m_left = 0; m_idx = 0;
      h_row = '0; h_col = '0; h_asc = '0; h_fg = '0; h_bg = '0;
      exp_q.delete();
      exp_q.push_back('0);
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", 32'(act), 32'(e));
      end
      e_r0 = 1'b0; e_r1 = 1'b0; n_we = 1'b0; n_oob = 1'b0; n_busy = 1'b0;
      if (m_left == 0 && clr_req) begin
        m_left = NCELL; m_idx = 0;
        m_fa = clr_ascii; m_ff = clr_fg; m_fb = clr_bg;
      end
      if (m_left > 0) begin
        n_we = 1'b1; n_busy = 1'b1;
        h_row = 5'(m_idx / COLS); h_col = 7'(m_idx % COLS);
        h_asc = m_fa; h_fg = m_ff; h_bg = m_fb;
        m_idx++; m_left--;
      end else begin
        g = -1;
        if (v0 && v1) g = (m_lg == 0) ? 1 : 0;
        else if (v0)  g = 0;
        else if (v1)  g = 1;
        if (g >= 0) begin
          m_lg = g;
          if (g == 0) e_r0 = 1'b1; else e_r1 = 1'b1;
          if ((g == 0 ? int'(row0) : int'(row1)) >= ROWS ||
              (g == 0 ? int'(col0) : int'(col1)) >= COLS) begin
            n_oob = 1'b1;
          end else begin
            n_we  = 1'b1;
            h_row = (g == 0) ? row0 : row1;
            h_col = (g == 0) ? col0 : col1;
            h_asc = (g == 0) ? asc0 : asc1;
            h_fg  = (g == 0) ? fg0  : fg1;
            h_bg  = (g == 0) ? bg0  : bg1;
          end
        end
      end
      check("ready", {30'd0, rdy0, rdy1}, {30'd0, e_r0, e_r1});
      exp_q.push_back({n_we, n_oob, n_busy, h_row, h_col, h_asc, h_fg, h_bg});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    v0 = 1'b0; v1 = 1'b0; clr_req = 1'b0;
  endtask

  function automatic logic [4:0] rnd_row();
    return 5'($urandom_range(0, 15) == 0 ? $urandom_range(0, 31) : $urandom_range(0, ROWS - 1));
  endfunction

  function automatic logic [6:0] rnd_col();
    return 7'($urandom_range(0, 15) == 0 ? $urandom_range(0, 127) : $urandom_range(0, COLS - 1));
  endfunction

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic       v0, v1;
    logic [4:0] r0;
    logic [6:0] c0;
    logic [4:0] r1;
    logic [6:0] c1;
    logic       er0, er1, ewe, eoob;
    logic [4:0] erow;
    logic [6:0] ecol;
  } vec_t;

  vec_t tbl[9];

  // ---------------- main sequence ----------------
  initial begin
    int k, nwr, first_rdy;
    logic acc0, acc1;

    rst_n = 1'b0;
    idle_inputs();
    clr_ascii = 8'h00; clr_fg = 3'd0; clr_bg = 3'd0;
    row0 = '0; col0 = '0; asc0 = 8'h41; fg0 = 3'd1; bg0 = 3'd2;
    row1 = '0; col1 = '0; asc1 = 8'h42; fg1 = 3'd3; bg1 = 3'd4;

    // round robin from reset (last_grant=1 -> req0 first), then range cases
    tbl[0] = '{1, 1, 5'd1,  7'd2,  5'd5,  7'd6,   1, 0, 1, 0, 5'd1,  7'd2};
    tbl[1] = '{1, 1, 5'd1,  7'd2,  5'd5,  7'd6,   0, 1, 1, 0, 5'd5,  7'd6};
    tbl[2] = '{1, 1, 5'd1,  7'd2,  5'd5,  7'd6,   1, 0, 1, 0, 5'd1,  7'd2};
    tbl[3] = '{1, 1, 5'd1,  7'd2,  5'd5,  7'd6,   0, 1, 1, 0, 5'd5,  7'd6};
    tbl[4] = '{0, 1, 5'd0,  7'd0,  5'd30, 7'd0,   0, 1, 0, 1, 5'd5,  7'd6};
    tbl[5] = '{0, 0, 5'd0,  7'd0,  5'd0,  7'd0,   0, 0, 0, 0, 5'd5,  7'd6};
    tbl[6] = '{1, 0, 5'd0,  7'd70, 5'd0,  7'd0,   1, 0, 0, 1, 5'd5,  7'd6};
    tbl[7] = '{1, 0, 5'd29, 7'd69, 5'd0,  7'd0,   1, 0, 1, 0, 5'd29, 7'd69};
    tbl[8] = '{1, 1, 5'd29, 7'd69, 5'd31, 7'd127, 0, 1, 0, 1, 5'd29, 7'd69};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset then idle: nothing is written
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_we", {31'd0, we}, 32'd0);
      next_cycle();
    end

    for (int i = 0; i < 9; i++) begin
      v0 = tbl[i].v0; v1 = tbl[i].v1;
      row0 = tbl[i].r0; col0 = tbl[i].c0;
      row1 = tbl[i].r1; col1 = tbl[i].c1;
      @(negedge clk);
      check("tbl_ready", {30'd0, rdy0, rdy1}, {30'd0, tbl[i].er0, tbl[i].er1});
      if (i > 0) begin
        check("tbl_we_oob", {30'd0, we, oob}, {30'd0, tbl[i-1].ewe, tbl[i-1].eoob});
        check("tbl_addr", {20'd0, wr_addr, wc_addr}, {20'd0, tbl[i-1].erow, tbl[i-1].ecol});
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    check("tbl_we_oob", {30'd0, we, oob}, {30'd0, tbl[8].ewe, tbl[8].eoob});
    check("tbl_addr", {20'd0, wr_addr, wc_addr}, {20'd0, tbl[8].erow, tbl[8].ecol});
    next_cycle();
    @(negedge clk);
    check("oob_one_cycle", {31'd0, oob}, 32'd0);
    next_cycle();

    // single write from req0
    v0 = 1'b1; row0 = 5'd3; col0 = 7'd10; asc0 = 8'h41; fg0 = 3'd2; bg0 = 3'd5;
    @(negedge clk);
    check("single_ready", {31'd0, rdy0}, 32'd1);
    next_cycle();
    v0 = 1'b0;
    @(negedge clk);
    check("single_out", {we, wr_addr, wc_addr, w_ascii, fg_color, bg_color},
          {1'b1, 5'd3, 7'd10, 8'h41, 3'd2, 3'd5});
    next_cycle();

    // clear sweep with both requesters waiting
    v0 = 1'b1; v1 = 1'b1;
    row0 = 5'd7; col0 = 7'd8; row1 = 5'd7; col1 = 7'd8;
    clr_req = 1'b1; clr_ascii = 8'h20; clr_fg = 3'd7; clr_bg = 3'd0;
    @(negedge clk);
    check("clr_accept_ready", {30'd0, rdy0, rdy1}, 32'd0);
    next_cycle();
    clr_req = 1'b0;
    k = 0; nwr = 0;
    while (k < 3000) begin
      @(negedge clk);
      k++;
      if (we && clr_busy) nwr++;
      if (k == 1)
        check("clr_first_cell", {we, clr_busy, wr_addr, wc_addr, w_ascii, fg_color, bg_color},
              {1'b1, 1'b1, 5'd0, 7'd0, 8'h20, 3'd7, 3'd0});
      if (k == NCELL)
        check("clr_last_cell", {we, clr_busy, wr_addr, wc_addr}, {1'b1, 1'b1, 5'd29, 7'd69});
      if (rdy0 || rdy1) break;
      #4;
    end
    check("clr_writes", nwr, NCELL);
    check("clr_ready_delay", k, NCELL);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("clr_first_req_write", {we, clr_busy, wr_addr, wc_addr}, {1'b1, 1'b0, 5'd7, 7'd8});
    next_cycle();

    // clr_req held across the end of a sweep: back-to-back sweeps
    v0 = 1'b1; row0 = 5'd2; col0 = 7'd2;
    clr_req = 1'b1;
    k = 0; first_rdy = -1;
    while (k < 5000) begin
      @(negedge clk);
      if (rdy0) begin first_rdy = k; break; end
      next_cycle();
      k++;
      if (k == NCELL + 1) clr_req = 1'b0;
    end
    check("clr_backtoback", first_rdy, 2 * NCELL);
    next_cycle();
    idle_inputs();
    next_cycle();

    // reset in the middle of a sweep
    clr_req = 1'b1;
    next_cycle();
    clr_req = 1'b0;
    k = 0;
    while (k < 3000) begin
      @(negedge clk);
      if (we && wr_addr == 5'd12 && wc_addr == 7'd40) break;
      k++;
    end
    check("mid_clear_found", (k < 3000) ? 32'd1 : 32'd0, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_we_busy", {30'd0, we, clr_busy}, 32'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    v0 = 1'b1; row0 = 5'd4; col0 = 7'd4;
    @(negedge clk);
    check("post_reset_ready", {31'd0, rdy0}, 32'd1);
    next_cycle();
    v0 = 1'b0;
    @(negedge clk);
    check("post_reset_write", {we, clr_busy, wr_addr, wc_addr}, {1'b1, 1'b0, 5'd4, 7'd4});
    next_cycle();

    // randomized traffic; payload is held until the handshake completes
    acc0 = 1'b0; acc1 = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!v0 || acc0) begin
        v0 = ($urandom_range(0, 2) != 0);
        row0 = rnd_row(); col0 = rnd_col();
        asc0 = 8'($urandom); fg0 = 3'($urandom); bg0 = 3'($urandom);
      end
      if (!v1 || acc1) begin
        v1 = ($urandom_range(0, 2) != 0);
        row1 = rnd_row(); col1 = rnd_col();
        asc1 = 8'($urandom); fg1 = 3'($urandom); bg1 = 3'($urandom);
      end
      clr_req = ($urandom_range(0, 799) == 0);
      if (clr_req) begin
        clr_ascii = 8'($urandom); clr_fg = 3'($urandom); clr_bg = 3'($urandom);
      end
      @(negedge clk);
      acc0 = rdy0; acc1 = rdy1;
      next_cycle();
    end
    idle_inputs();
    repeat (NCELL + 5) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
